// File: rtl/decode_stage.sv
// MIPS decode pipeline stage: one instruction in, one registered
// control bundle out, with load-use interlock, flush and stall counter.
module decode_stage #(
  parameter int unsigned RA_REG    = 31,
  parameter int unsigned EXT_OPS   = 0,
  parameter int unsigned HAZARD_EN = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [31:0]      in_instr_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [3:0]       out_alu_op_o,
  output logic             out_alu_b_reg_o,
  output logic [4:0]       out_rs1_addr_o,
  output logic [4:0]       out_rs2_addr_o,
  output logic [4:0]       out_rd_addr_o,
  output logic             out_rd_we_o,
  output logic [1:0]       out_src_rd_o,
  output logic [31:0]      out_imm_o,
  output logic             out_store_o,
  output logic [2:0]       out_cf_o,
  output logic             out_illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_PC4 = 2'd2;
  localparam logic [3:0] INSTR_ADD = 4'b0000;
  localparam logic [2:0] CF_BEQ = 3'd1;
  localparam logic [2:0] CF_BNE = 3'd2;
  localparam logic [2:0] CF_J   = 3'd3;
  localparam logic [2:0] CF_JAL = 3'd4;
  localparam logic [2:0] CF_JR  = 3'd5;
  localparam logic [4:0] RA_ADDR = 5'(RA_REG);
  localparam bit EXT_ON = (EXT_OPS != 0);
  localparam bit HAZ_ON = (HAZARD_EN != 0);

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        b_reg;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  src;
    logic [31:0] imm;
    logic        store;
    logic [2:0]  cf;
    logic        illegal;
    logic        is_load;
  } bundle_t;

  bundle_t dec;
  bundle_t bun_q, bun_d;
  logic valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic uses_rt;
  logic hazard;
  logic accept;

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] sext, zext, jimm;
  logic        r_alu;

  assign op    = in_instr_i[31:26];
  assign rs    = in_instr_i[25:21];
  assign rt    = in_instr_i[20:16];
  assign rd    = in_instr_i[15:11];
  assign shamt = in_instr_i[10:6];
  assign funct = in_instr_i[5:0];
  assign sext  = {{16{in_instr_i[15]}}, in_instr_i[15:0]};
  assign zext  = {16'd0, in_instr_i[15:0]};
  assign jimm  = {4'd0, in_instr_i[25:0], 2'b00};
  assign r_alu = (shamt == 5'd0) &&
    (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
     funct == 6'h25 || funct == 6'h2A);

  // Decode the incoming word into a control bundle.
  always_comb begin
    dec     = '0;
    uses_rt = 1'b0;
    dec.rs1 = rs;
    dec.rs2 = rt;
    dec.src = SRC_ALU;
    unique case (op)
      6'h00: begin
        if (r_alu) begin
          dec.alu_op = funct[3:0];
          dec.b_reg  = 1'b1;
          dec.rd     = rd;
          dec.we     = 1'b1;
          uses_rt    = 1'b1;
        end else if (funct == 6'h08) begin
          dec.cf = CF_JR;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      6'h23: begin
        dec.alu_op  = INSTR_ADD;
        dec.rd      = rt;
        dec.we      = 1'b1;
        dec.src     = SRC_MEM;
        dec.imm     = sext;
        dec.is_load = 1'b1;
      end
      6'h2B: begin
        dec.alu_op = INSTR_ADD;
        dec.rd     = rt;
        dec.imm    = sext;
        dec.store  = 1'b1;
        uses_rt    = 1'b1;
      end
      6'h08, 6'h0C: begin
        dec.alu_op = {1'b0, op[2:0]};
        dec.rd     = rt;
        dec.we     = 1'b1;
        dec.imm    = op[2] ? zext : sext;
      end
      6'h0D: begin
        if (EXT_ON) begin
          dec.alu_op = {1'b0, op[2:0]};
          dec.rd     = rt;
          dec.we     = 1'b1;
          dec.imm    = zext;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      6'h0A: begin
        if (EXT_ON) begin
          dec.alu_op = 4'b1010;
          dec.rd     = rt;
          dec.we     = 1'b1;
          dec.imm    = sext;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      6'h04, 6'h05: begin
        dec.rd  = rt;
        dec.imm = sext;
        dec.cf  = op[0] ? CF_BNE : CF_BEQ;
        uses_rt = 1'b1;
      end
      6'h02: begin
        dec.imm = jimm;
        dec.cf  = CF_J;
      end
      6'h03: begin
        dec.rd  = RA_ADDR;
        dec.we  = 1'b1;
        dec.src = SRC_PC4;
        dec.imm = jimm;
        dec.cf  = CF_JAL;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Load-use interlock and input handshake.
  always_comb begin
    hazard = HAZ_ON && in_valid_i && valid_q &&
      bun_q.is_load && (bun_q.rd != 5'd0) &&
      ((rs == bun_q.rd) || (uses_rt && (rt == bun_q.rd)));
    in_ready_o = !flush_i && !hazard &&
      (!valid_q || out_ready_i);
    accept = in_valid_i && in_ready_o;
  end

  // Next-state for output register and stall counter.
  always_comb begin
    valid_d = valid_q;
    bun_d   = bun_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      bun_d   = dec;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
    if (!flush_i && hazard && out_ready_i &&
        (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      bun_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bun_q   <= bun_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid_o     = valid_q;
  assign out_alu_op_o    = bun_q.alu_op;
  assign out_alu_b_reg_o = bun_q.b_reg;
  assign out_rs1_addr_o  = bun_q.rs1;
  assign out_rs2_addr_o  = bun_q.rs2;
  assign out_rd_addr_o   = bun_q.rd;
  assign out_rd_we_o     = bun_q.we;
  assign out_src_rd_o    = bun_q.src;
  assign out_imm_o       = bun_q.imm;
  assign out_store_o     = bun_q.store;
  assign out_cf_o        = bun_q.cf;
  assign out_illegal_o   = bun_q.illegal;
  assign stall_cnt_o     = cnt_q;

endmodule
